pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised, elastic successor to the single load-enabled register.
- A chain of DEPTH register stages, each holding a WIDTH-bit data word, a 1-bit side flag and a valid bit.
- Uses a valid/ready handshake with per-stage bubble collapsing and a synchronous flush.
- Sits between datapath units that previously used plain ld-gated registers, so they can stall independently without losing data.

Parameters:
- WIDTH, 2: data word width in bits (>=1).
- DEPTH, 3: number of register stages (>=1).
- CW, $clog2(DEPTH+1): width of the occupancy output (derived; not overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  upstream presents a word.
- in_ready  output  1  chain accepts a word this cycle.
- in_data  input  WIDTH  upstream data word.
- in_flag  input  1  upstream side flag, travels with in_data.
- out_valid  output  1  last stage holds a word.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  data of last stage.
- out_flag  output  1  flag of last stage.
- occupancy  output  CW  number of valid stages, 0..DEPTH.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - On reset, all stage valid, data and flag registers clear to 0, and occupancy clears to 0.
  - Hence out_valid=0, out_data=0, out_flag=0, occupancy=0.
  - in_ready=1 after reset, provided flush=0.
- Stage k runs 0..DEPTH-1; stage DEPTH-1 drives the outputs directly from registers, with no output logic beyond flush gating.
- Ready chain:
  - ready[DEPTH] = out_ready.
  - ready[k] = !v[k] | ready[k+1].
  - in_ready = ready[0] & !flush.
  - This path is combinational across the chain; no registered-ready/skid behaviour is required.
- Stage advance: when ready[k] is high, v[k] <= upstream valid.
  - Upstream valid is in_valid & in_ready for k=0, and v[k-1] for k>0.
  - d[k] and f[k] load from upstream only when ready[k] and the upstream valid are both high; otherwise they hold.
  - When ready[k] is low, the stage holds everything.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_data/in_flag are ignored when no input transfer occurs.
- Latency: with out_ready held high, a word accepted at edge N appears on out_* after edge N+DEPTH-1 (DEPTH edges from acceptance to leaving the last stage).
- Throughput: one word per cycle when out_ready=1.
- Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Full: when all DEPTH stages are valid and out_ready=0, in_ready=0 and all contents are held indefinitely, with no loss and no duplication.
- Full with out_ready=1: input is accepted in the same cycle (pass-through of ready); occupancy is unchanged.
- Flush:
  - Priority over everything except rst.
  - At the edge, all v[k] clear to 0 and occupancy goes to 0; data/flag registers hold their stale values.
  - During the flush cycle, in_ready=0 (input dropped) and out_valid is forced to 0 combinationally, so no output transfer occurs.
- occupancy: a registered counter, not a popcount.
  - +1 on an input transfer only.
  - -1 on an output transfer only.
  - Unchanged when both or neither occur.
  - 0 on flush.
  - Must always equal the number of set valid bits; a bench assertion checks this.
- Ordering: words exit in the order accepted, with data and flag always paired.
- Reset mid-operation: contents are discarded immediately (asynchronous) with no partial transfer; the first cycle after reset deassertion behaves as empty.
- DEPTH=1: degenerates to a single valid-qualified register with ready pass-through; all rules above still hold.

Test Plan:
- Reset then streaming (WIDTH=2, DEPTH=3), out_ready=1: inject words 1,2,3,0 with flags 1,0,1,0 on consecutive cycles. The first output appears 3 edges after acceptance, order and flags are preserved, occupancy settles at 3, and the chain returns to 0 after input stops.
- Back-pressure fill: out_ready=0 with in_valid=1 continuously. Exactly 3 words are accepted, then in_ready=0 and occupancy=3; outputs hold for 10 cycles. Then set out_ready=1 and drain: exactly 3 words exit with no duplicates.
- Bubble collapse: load one word, hold out_ready=0, and inject a second word 2 cycles later. Both are accepted, occupancy=2, and with out_ready=1 they drain on consecutive cycles.
- Full pass-through: chain full, out_ready=1 and in_valid=1 for 5 cycles. in_ready=1 every cycle, occupancy stays 3, and 5 words exit in order.
- Flush: with 2 words in the chain and in_valid=1, assert flush for 1 cycle. In that cycle out_valid=0 and in_ready=0; next cycle occupancy=0 and the flushed words never appear.
- Async reset mid-stream: assert rst between clock edges while full. Outputs go to 0 immediately, and after release the first accepted word appears after DEPTH edges.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic valid/ready register chain with bubble collapsing,
// synchronous flush and a registered occupancy counter.
module pipe_reg_chain #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_flag,
  output logic [CW-1:0]    occupancy
);
  logic [DEPTH-1:0] v_q, v_d, f_q, f_up, up_v, ld, rdy;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_up;
  logic [CW-1:0] occ_q, occ_d;
  logic in_xfer, out_xfer, r;
  // A stage is ready when it or any stage after it is empty, or the sink takes a word.
  always_comb begin
    r = out_ready;
    rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r = !v_q[k] | r;
      rdy[k] = r;
    end
    in_ready = rdy[0] & !flush;
    in_xfer = in_valid & in_ready;
    out_valid = v_q[DEPTH-1] & !flush;
    out_xfer = out_valid & out_ready;
    up_v = '0;
    d_up = '0;
    f_up = '0;
    up_v[0] = in_xfer;
    d_up[0] = in_data;
    f_up[0] = in_flag;
    for (int k = 1; k < DEPTH; k++) begin
      up_v[k] = v_q[k-1];
      d_up[k] = d_q[k-1];
      f_up[k] = f_q[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      v_d[k] = flush ? 1'b0 : rdy[k] ? up_v[k] : v_q[k];
      ld[k] = rdy[k] & up_v[k] & !flush;
    end
    occ_d = flush ? '0 :
            (in_xfer & !out_xfer) ? occ_q + 1'b1 :
            (out_xfer & !in_xfer) ? occ_q - 1'b1 : occ_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      f_q <= '0;
      d_q <= '0;
      occ_q <= '0;
    end else begin
      v_q <= v_d;
      occ_q <= occ_d;
      for (int k = 0; k < DEPTH; k++) begin
        if (ld[k]) begin
          d_q[k] <= d_up[k];
          f_q[k] <= f_up[k];
        end
      end
    end
  end
  assign out_data = d_q[DEPTH-1];
  assign out_flag = f_q[DEPTH-1];
  assign occupancy = occ_q;
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed stimulus with a queue scoreboard; a negedge
// monitor pops and compares every word leaving the chain.
module tb_pipe_reg_chain;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_flag = 1'b0, out_ready = 1'b0;
  logic [1:0] in_data = '0;
  logic in_ready, out_valid, out_flag;
  logic [1:0] out_data, occupancy;
  logic [2:0] q[$];
  int tests = 0, fails = 0;

  pipe_reg_chain #(.WIDTH(2), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_flag(in_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flag(out_flag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy against the scoreboard depth and valid bits, then any exiting word.
  always @(negedge clk) begin
    if (!rst) begin
      chk("occupancy", int'(occupancy), q.size());
      chk("occ_vs_valid", int'(occupancy), $countones(dut.v_q));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", int'({out_flag, out_data}), -1);
        else chk("out_word", int'({out_flag, out_data}), int'(q.pop_front()));
      end
    end
  end

  task automatic step(input logic iv, input logic [1:0] d, input logic f, input logic ordy,
                      input logic fl, input logic exp_ir, input logic exp_ov);
    @(posedge clk);
    #1;
    in_valid = iv;
    in_data = d;
    in_flag = f;
    out_ready = ordy;
    flush = fl;
    #5;
    chk("in_ready", int'(in_ready), int'(exp_ir));
    chk("out_valid", int'(out_valid), int'(exp_ov));
    if (iv && exp_ir) q.push_back({f, d});
    if (fl) q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_flag", int'(out_flag), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    // Streaming: first word visible three edges after acceptance
    step(1, 2'd1, 1, 1, 0, 1, 0);
    step(1, 2'd2, 0, 1, 0, 1, 0);
    step(1, 2'd3, 1, 1, 0, 1, 0);
    step(1, 2'd0, 0, 1, 0, 1, 1);
    step(0, 2'd3, 1, 1, 0, 1, 1);
    step(0, 2'd3, 1, 1, 0, 1, 1);
    step(0, 2'd3, 1, 1, 0, 1, 1);
    step(0, 2'd3, 1, 1, 0, 1, 0);
    chk("stream_empty", int'(occupancy), 0);
    // Back-pressure fill, 10-cycle hold, drain
    step(1, 2'd1, 1, 0, 0, 1, 0);
    step(1, 2'd2, 0, 0, 0, 1, 0);
    step(1, 2'd3, 1, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 2'(i), i[0], 0, 0, 0, 1);
    chk("full_occupancy", int'(occupancy), 3);
    step(0, 2'd0, 0, 1, 0, 1, 1);
    step(0, 2'd0, 0, 1, 0, 1, 1);
    step(0, 2'd0, 0, 1, 0, 1, 1);
    step(0, 2'd0, 0, 1, 0, 1, 0);
    // Bubble collapse
    step(1, 2'd2, 1, 0, 0, 1, 0);
    step(0, 2'd0, 0, 0, 0, 1, 0);
    step(0, 2'd0, 0, 0, 0, 1, 0);
    step(1, 2'd1, 0, 0, 0, 1, 1);
    step(0, 2'd0, 0, 0, 0, 1, 1);
    step(0, 2'd0, 0, 0, 0, 1, 1);
    chk("bubble_occupancy", int'(occupancy), 2);
    step(0, 2'd0, 0, 1, 0, 1, 1);
    step(0, 2'd0, 0, 1, 0, 1, 1);
    step(0, 2'd0, 0, 1, 0, 1, 0);
    // Full pass-through
    step(1, 2'd3, 0, 0, 0, 1, 0);
    step(1, 2'd2, 1, 0, 0, 1, 0);
    step(1, 2'd1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 2'(i), ~i[0], 1, 0, 1, 1);
    step(0, 2'd0, 0, 1, 0, 1, 1);
    step(0, 2'd0, 0, 1, 0, 1, 1);
    step(0, 2'd0, 0, 1, 0, 1, 1);
    step(0, 2'd0, 0, 1, 0, 1, 0);
    // Flush with two words resident, one already in the last stage
    step(1, 2'd2, 1, 0, 0, 1, 0);
    step(1, 2'd3, 0, 0, 0, 1, 0);
    step(0, 2'd0, 0, 0, 0, 1, 0);
    step(1, 2'd1, 1, 1, 1, 0, 0);
    step(0, 2'd0, 0, 1, 0, 1, 0);
    chk("flush_occupancy", int'(occupancy), 0);
    step(0, 2'd0, 0, 1, 0, 1, 0);
    step(0, 2'd0, 0, 1, 0, 1, 0);
    // Asynchronous reset while full
    step(1, 2'd1, 1, 0, 0, 1, 0);
    step(1, 2'd2, 1, 0, 0, 1, 0);
    step(1, 2'd3, 0, 0, 0, 1, 0);
    step(0, 2'd0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    q.delete();
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_out_flag", int'(out_flag), 0);
    chk("arst_occupancy", int'(occupancy), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    step(1, 2'd2, 0, 1, 0, 1, 0);
    step(0, 2'd0, 0, 1, 0, 1, 0);
    step(0, 2'd0, 0, 1, 0, 1, 0);
    step(0, 2'd0, 0, 1, 0, 1, 1);
    step(0, 2'd0, 0, 1, 0, 1, 0);
    @(posedge clk);
    #6;
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
